// File: rtl/text_scanner.sv
// Text-mode raster scanner: generates video timing, fetches character codes from
// text RAM, feeds character_rom and re-aligns the returned dot with delayed syncs.
module text_scanner #(
  parameter int   H_ACTIVE      = 640,
  parameter int   H_FRONT       = 16,
  parameter int   H_SYNC        = 96,
  parameter int   H_BACK        = 48,
  parameter int   V_ACTIVE      = 480,
  parameter int   V_FRONT       = 10,
  parameter int   V_SYNC        = 2,
  parameter int   V_BACK        = 33,
  parameter int   COLUMNS       = 80,
  parameter int   ADDRESS_WIDTH = 13,
  parameter logic SYNC_POLARITY = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [ADDRESS_WIDTH-1:0] text_address,
  input  logic [6:0]               text_data,
  output logic [2:0]               x,
  output logic [2:0]               y,
  output logic [6:0]               character,
  input  logic                     dot,
  output logic                     pixel,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_BITS  = $clog2(H_TOTAL + 1);
  localparam int V_BITS  = $clog2(V_TOTAL + 1);

  localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(H_TOTAL - 1);
  localparam logic [H_BITS-1:0] H_VIS    = H_BITS'(H_ACTIVE);
  localparam logic [H_BITS-1:0] HS_START = H_BITS'(H_ACTIVE + H_FRONT);
  localparam logic [H_BITS-1:0] HS_END   = H_BITS'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(V_TOTAL - 1);
  localparam logic [V_BITS-1:0] V_VIS    = V_BITS'(V_ACTIVE);
  localparam logic [V_BITS-1:0] VS_START = V_BITS'(V_ACTIVE + V_FRONT);
  localparam logic [V_BITS-1:0] VS_END   = V_BITS'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [ADDRESS_WIDTH-1:0] ROW_STEP = ADDRESS_WIDTH'(COLUMNS);

  logic [H_BITS-1:0]        h_count_reg, h_count_next;
  logic [V_BITS-1:0]        v_count_reg, v_count_next;
  logic [ADDRESS_WIDTH-1:0] row_base_reg, row_base_next;
  logic [ADDRESS_WIDTH-1:0] column;
  logic                     h_wrap, v_wrap;
  logic                     active, hsync_raw, vsync_raw, frame_raw;
  logic                     hs_level, vs_level;

  logic [2:0] x_reg, y_reg;
  logic [1:0] active_pipe_reg;
  logic       pixel_reg;
  logic [2:0] hs_pipe_reg, vs_pipe_reg, fs_pipe_reg;

  always_comb begin
    h_wrap        = (h_count_reg == H_LAST);
    v_wrap        = (v_count_reg == V_LAST);
    h_count_next  = h_count_reg + 1'b1;
    v_count_next  = v_count_reg;
    row_base_next = row_base_reg;
    if (h_wrap) begin
      h_count_next = '0;
      v_count_next = v_wrap ? '0 : v_count_reg + 1'b1;
      // A frame wrap wins over the end-of-character-row advance
      if (v_wrap)
        row_base_next = '0;
      else if (v_count_reg[2:0] == 3'd7)
        row_base_next = row_base_reg + ROW_STEP;
    end
  end

  always_comb begin
    active    = (h_count_reg < H_VIS) && (v_count_reg < V_VIS);
    hsync_raw = (h_count_reg >= HS_START) && (h_count_reg < HS_END);
    vsync_raw = (v_count_reg >= VS_START) && (v_count_reg < VS_END);
    frame_raw = (h_count_reg == '0) && (v_count_reg == '0);
    hs_level  = hsync_raw ? SYNC_POLARITY : ~SYNC_POLARITY;
    vs_level  = vsync_raw ? SYNC_POLARITY : ~SYNC_POLARITY;
  end

  assign column       = ADDRESS_WIDTH'(h_count_reg[H_BITS-1:3]);
  assign text_address = active ? row_base_reg + column : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      h_count_reg     <= '0;
      v_count_reg     <= '0;
      row_base_reg    <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      active_pipe_reg <= '0;
      pixel_reg       <= 1'b0;
      hs_pipe_reg     <= {3{~SYNC_POLARITY}};
      vs_pipe_reg     <= {3{~SYNC_POLARITY}};
      fs_pipe_reg     <= '0;
    end else begin
      h_count_reg     <= h_count_next;
      v_count_reg     <= v_count_next;
      row_base_reg    <= row_base_next;
      x_reg           <= h_count_reg[2:0];
      y_reg           <= v_count_reg[2:0];
      // Two stages of active bring it level with the ROM dot
      active_pipe_reg <= {active_pipe_reg[0], active};
      pixel_reg       <= dot & active_pipe_reg[1];
      hs_pipe_reg     <= {hs_pipe_reg[1:0], hs_level};
      vs_pipe_reg     <= {vs_pipe_reg[1:0], vs_level};
      fs_pipe_reg     <= {fs_pipe_reg[1:0], frame_raw};
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign character   = text_data;
  assign pixel       = pixel_reg;
  assign hsync       = hs_pipe_reg[2];
  assign vsync       = vs_pipe_reg[2];
  assign frame_start = fs_pipe_reg[2];

endmodule

// File: tb/tb_text_scanner.sv
// Self-checking bench for text_scanner on a small raster, with text RAM and
// character ROM models and a position-based reference model.
module tb_text_scanner;
  localparam int HA = 16, HF = 2, HS = 2, HB = 2;
  localparam int VA = 16, VF = 1, VS = 1, VB = 1;
  localparam int COLS = 2, AW = 13;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] text_address;
  logic [6:0]    text_data = 7'd0;
  logic [2:0]    x, y;
  logic [6:0]    character;
  logic          dot = 1'b0;
  logic          pixel, hsync, vsync, frame_start;

  int errors = 0;
  int checks = 0;
  int since = 0;
  int cyc = 0;
  int last_fs = -1;
  bit have_reset = 1'b0;
  bit force_one = 1'b1;

  text_scanner #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .COLUMNS(COLS), .ADDRESS_WIDTH(AW), .SYNC_POLARITY(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .text_address(text_address),
    .text_data(text_data), .x(x), .y(y), .character(character), .dot(dot),
    .pixel(pixel), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  // Raster position after s clocks of free running since reset
  function automatic int h_of(int s);
    return (s % FRAME) % HT;
  endfunction
  function automatic int v_of(int s);
    return (s % FRAME) / HT;
  endfunction
  function automatic bit is_active(int s);
    return (h_of(s) < HA) && (v_of(s) < VA);
  endfunction
  function automatic int addr_of(int s);
    if (!is_active(s)) return 0;
    return (v_of(s) / 8) * COLS + h_of(s) / 8;
  endfunction
  function automatic bit hs_on(int s);
    return (h_of(s) >= HA + HF) && (h_of(s) < HA + HF + HS);
  endfunction
  function automatic bit vs_on(int s);
    return (v_of(s) >= VA + VF) && (v_of(s) < VA + VF + VS);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d since_reset=%0d got=%0d expected=%0d",
               name, cyc, since, act, exp);
    end
  endtask

  // Text RAM (address n holds 65+n) and character ROM; blank-time dots are junk
  always @(posedge clock) begin
    text_data <= 7'(65 + int'(text_address));
    if (since >= 1 && is_active(since - 1))
      dot <= x[0] ^ y[0];
    else
      dot <= force_one ? 1'b1 : 1'($urandom_range(0, 1));
    cyc <= cyc + 1;
    if (reset) begin
      since      <= 0;
      have_reset <= 1'b1;
    end else begin
      since <= since + 1;
    end
  end

  always @(negedge clock) begin
    int s;
    if (have_reset) begin
      s = since;
      check("text_address", int'(text_address), addr_of(s));
      if (s >= 1) begin
        check("character", int'(character), 65 + addr_of(s - 1));
        check("x", int'(x), h_of(s - 1) % 8);
        check("y", int'(y), v_of(s - 1) % 8);
      end else begin
        check("x", int'(x), 0);
        check("y", int'(y), 0);
      end
      if (s >= 3) begin
        check("pixel", int'(pixel),
              is_active(s - 3) ? (h_of(s - 3) + v_of(s - 3)) % 2 : 0);
        check("hsync", int'(hsync), hs_on(s - 3) ? 0 : 1);
        check("vsync", int'(vsync), vs_on(s - 3) ? 0 : 1);
        check("frame_start", int'(frame_start), ((s - 3) % FRAME == 0) ? 1 : 0);
      end else begin
        check("pixel", int'(pixel), 0);
        check("hsync", int'(hsync), 1);
        check("vsync", int'(vsync), 1);
        check("frame_start", int'(frame_start), 0);
      end

      case (s)
        0: begin
          check("lit_reset_pixel", int'(pixel), 0);
          check("lit_reset_hsync", int'(hsync), 1);
          check("lit_reset_vsync", int'(vsync), 1);
          check("lit_reset_fs", int'(frame_start), 0);
          check("lit_reset_addr", int'(text_address), 0);
        end
        1:   check("lit_char_first", int'(character), 65);
        4:   check("lit_pixel_h1", int'(pixel), 1);
        8:   check("lit_addr_col1", int'(text_address), 1);
        9:   check("lit_char_second", int'(character), 66);
        16:  check("lit_addr_hblank", int'(text_address), 0);
        20:  check("lit_hsync_before", int'(hsync), 1);
        21:  check("lit_hsync_first", int'(hsync), 0);
        22:  check("lit_hsync_second", int'(hsync), 0);
        23:  check("lit_hsync_after", int'(hsync), 1);
        176: check("lit_addr_row1", int'(text_address), 2);
        376: check("lit_vsync_before", int'(vsync), 1);
        377: check("lit_vsync_first", int'(vsync), 0);
        398: check("lit_vsync_last", int'(vsync), 0);
        399: check("lit_vsync_after", int'(vsync), 1);
        418: check("lit_addr_next_frame", int'(text_address), 0);
        default: ;
      endcase

      if (s == 0) last_fs = -1;
      if (frame_start) begin
        if (last_fs >= 0) check("frame_period", cyc - last_fs, FRAME);
        else              check("first_frame_start", s, 3);
        last_fs = cyc;
      end
    end
  end

  initial begin
    int target;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // First frame and a bit with blank-time dots forced high, then reset at v=10
    target = FRAME + 10 * HT + $urandom_range(0, HT - 1);
    repeat (target) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    force_one = 1'b0;
    repeat (2 * FRAME + 30) @(negedge clock);

    reset = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clock);
    reset = 1'b0;
    repeat (FRAME + 50) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/text_scanner.md
Name: text_scanner

Overview:
- Text-mode video scanner that sits directly upstream of character_rom.
- Generates raster timing with horizontal and vertical counters.
- Fetches character codes from a synchronous text RAM and drives character_rom with x, y and the character code.
- Registers the returned dot into an aligned pixel stream, together with delay-matched hsync and vsync for the display output.

Parameters:
- H_ACTIVE, 640, visible pixels per line (multiple of 8)
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame (multiple of 8)
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- COLUMNS, 80, character columns per row; equals H_ACTIVE/8
- ADDRESS_WIDTH, 13, text RAM address width; must hold COLUMNS*(V_ACTIVE/8)-1
- SYNC_POLARITY, 0, level of hsync and vsync while asserted (0 = active-low)

Ports:
- clock  input  1  pixel clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- text_address  output  ADDRESS_WIDTH  text RAM read address; combinational from registered state
- text_data  input  7  character code returned by the text RAM one clock after text_address
- x  output  3  glyph column to character_rom (registered)
- y  output  3  glyph row to character_rom (registered)
- character  output  7  character code to character_rom; wired directly from text_data
- dot  input  1  glyph dot from character_rom, valid one clock after x/y/character
- pixel  output  1  final video dot (registered)
- hsync  output  1  horizontal sync (registered)
- vsync  output  1  vertical sync (registered)
- frame_start  output  1  one-clock pulse aligned with the pixel at position (0,0)

Behaviour:
- Counters
  - h_count runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; wraps to 0.
  - v_count increments only when h_count wraps. It runs 0..V_TOTAL-1, where V_TOTAL is the equivalent vertical sum, then wraps to 0.
- active = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- hsync_raw is asserted for H_ACTIVE+H_FRONT <= h_count < H_ACTIVE+H_FRONT+H_SYNC. vsync_raw uses the equivalent vertical window.
- Row base register row_base (ADDRESS_WIDTH bits)
  - On h_count wrap with v_count[2:0]==7, add COLUMNS.
  - On v_count wrap, load 0. Wrap has priority when both happen.
- text_address
  - row_base + h_count[.. :3] while active; 0 otherwise.
  - Never exceeds COLUMNS*(V_ACTIVE/8)-1.
- Pipeline, for a counter position at cycle T0:
  - T0: text_address is presented.
  - T1: text_data is valid. x = h_count[2:0] and y = v_count[2:0] have been registered at the T0→T1 edge. character = text_data.
  - T2: dot is valid.
  - T3 (registered output): pixel = dot_T2 & active (delayed two stages).
    - hsync, vsync and frame_start are delayed three stages, so all three align with pixel.
    - Sync outputs present SYNC_POLARITY when asserted and ~SYNC_POLARITY otherwise.
- Latency: counter position to pixel is 3 clocks.
- frame_start is raw-asserted when h_count==0 and v_count==0, then delayed three stages. It pulses exactly once per frame.
- Reset (synchronous, takes priority over everything)
  - h_count, v_count, row_base and all pipeline registers go to 0.
  - x=0, y=0, pixel=0, frame_start=0.
  - hsync and vsync = ~SYNC_POLARITY, i.e. inactive, including their delay stages.
  - Reset asserted mid-frame restarts at (0,0) on the next cycle. After reset deasserts, the first frame_start appears 3 clocks later.
- Blanking: pixel=0 regardless of dot. text_data and dot are ignored.

Test Plan:
- Small configuration for all scenarios: H_ACTIVE=16, H_FRONT=2, H_SYNC=2, H_BACK=2, V_ACTIVE=16, V_FRONT=1, V_SYNC=1, V_BACK=1, COLUMNS=2, SYNC_POLARITY=0.
- The bench models the text RAM (1-clock latency, address n returns 65+n) and the character ROM (1-clock latency, dot = x[0]^y[0]).
- Reset held 3 clocks → pixel=0, hsync=1, vsync=1, frame_start=0, text_address=0. frame_start pulses exactly at clock 3 after release.
- Line scan → text_address sequence 0 (h 0..7), 1 (h 8..15), then 0 during blank. character equals 65 then 66, lagging the address by one clock.
- Row advance → text_address is 2 at v_count=8, h_count=0, and returns to 0 on the next frame. Total frame period is 22*19=418 clocks between frame_start pulses.
- Sync timing → hsync low for exactly 2 clocks starting 3 clocks after h_count=18. vsync low for exactly one 22-clock line starting at v_count=17 (+3 clocks).
- Pixel data → in line 0, pixel pattern 0,1,0,1,… beginning 3 clocks after h_count=0. Forcing the ROM dot to 1 during blanking yields pixel=0.
- Mid-frame reset at v_count=10 → next cycle counters are 0. Outputs return to their reset values, and the scan resumes with text_address 0.
